// File: rtl/adder_ctrl_pkg.sv
// adder_ctrl_pkg: shared types and helpers for the nibble-serial adder sequencer
//   NIBBLE_W   : width of the shared adder datapath
//   state_t    : sequencer states
//   signed_ovf : two's complement overflow from operand/sum MSBs
package adder_ctrl_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/ripple_carry_adder_4.sv
// ripple_carry_adder_4: 4-bit ripple carry adder
//   i_a, i_b    : addends
//   i_carry_in  : carry into bit 0
//   o_s         : 4-bit sum
//   o_carry_out : carry out of bit 3
module ripple_carry_adder_4 (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_carry_in,
   output logic [3:0] o_s,
   output logic       o_carry_out
);

   logic [4:0] w_c;

   assign w_c[0] = i_carry_in;

   for (genvar g = 0; g < 4; g++) begin : g_fa
      assign o_s[g]     = i_a[g] ^ i_b[g] ^ w_c[g];
      assign w_c[g + 1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
   end

   assign o_carry_out = w_c[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: WIDTH-bit adder sequencing one 4-bit adder over nibbles, LSB first
//   i_clk, i_rst_n              : clock, synchronous active-low reset
//   i_valid/o_ready             : operand handshake (ready only in IDLE)
//   i_a, i_b, i_carry_in        : operands, captured on acceptance
//   o_valid/i_ready             : result handshake (valid only in DONE)
//   o_s, o_carry_out, o_overflow: result, zero outside DONE
module nibble_serial_adder_ctrl
   import adder_ctrl_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_carry_in,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_s,
   output logic             o_carry_out,
   output logic             o_overflow
);

   localparam int NUM_NIB = WIDTH / NIBBLE_W;
   localparam int IDX_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIB - 1);

   if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
      $error("nibble_serial_adder_ctrl: WIDTH must be a positive multiple of 4");
   end

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_a, r_b, r_sum;
   logic             r_carry;
   logic [IDX_W-1:0] r_idx;
   logic [NIBBLE_W-1:0] w_nib_s;
   logic             w_nib_c;
   logic             w_done;

   ripple_carry_adder_4 u_rca (
      .i_a         (r_a[NIBBLE_W*r_idx +: NIBBLE_W]),
      .i_b         (r_b[NIBBLE_W*r_idx +: NIBBLE_W]),
      .i_carry_in  (r_carry),
      .o_s         (w_nib_s),
      .o_carry_out (w_nib_c)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == IDLE && i_valid) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_carry <= i_carry_in;
            r_idx   <= '0;
         end
         if (r_state == ADD) begin
            r_sum[NIBBLE_W*r_idx +: NIBBLE_W] <= w_nib_s;
            r_carry <= w_nib_c;
            r_idx   <= r_idx + 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    w_state_nxt = i_valid ? ADD : IDLE;
         ADD:     w_state_nxt = (r_idx == LAST_IDX) ? DONE : ADD;
         DONE:    w_state_nxt = i_ready ? IDLE : DONE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Result outputs are gated by the registered state so they read zero outside DONE.
   assign w_done      = (r_state == DONE);
   assign o_ready     = (r_state == IDLE);
   assign o_valid     = w_done;
   assign o_s         = w_done ? r_sum : '0;
   assign o_carry_out = w_done & r_carry;
   assign o_overflow  = w_done & signed_ovf(r_a[WIDTH-1], r_b[WIDTH-1], r_sum[WIDTH-1]);

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: directed scoreboard bench for nibble_serial_adder_ctrl (WIDTH=16)
module tb_nibble_serial_adder_ctrl;

   typedef struct packed {
      logic [15:0] s;
      logic        c;
      logic        v;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [15:0] i_a = '0;
   logic [15:0] i_b = '0;
   logic        i_carry_in = 1'b0;
   logic        o_valid;
   logic        i_ready = 1'b1;
   logic [15:0] o_s;
   logic        o_carry_out;
   logic        o_overflow;

   int   checks = 0;
   int   errors = 0;
   exp_t q[$];

   always #5 clk = ~clk;

   nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_a         (i_a),
      .i_b         (i_b),
      .i_carry_in  (i_carry_in),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_s         (o_s),
      .o_carry_out (o_carry_out),
      .o_overflow  (o_overflow)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one operand set for the accept cycle and record the reference result.
   task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic cin);
      exp_t e;
      logic [16:0] full;
      full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      e.s  = full[15:0];
      e.c  = full[16];
      e.v  = (a[15] == b[15]) && (e.s[15] != a[15]);
      check("ready_before_accept", {31'd0, o_ready}, 32'd1);
      i_valid    = 1'b1;
      i_a        = a;
      i_b        = b;
      i_carry_in = cin;
      q.push_back(e);
      tick();
      i_valid = 1'b0;
   endtask

   // Wait (bounded) for o_valid, then compare against the oldest expected result.
   task automatic get_result(input string tag, input logic chk_lat);
      exp_t e;
      int   n = 1;
      while (o_valid !== 1'b1 && n < 20) begin
         check({tag, "_busy_ready"}, {31'd0, o_ready}, 32'd0);
         tick();
         n++;
      end
      check({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
      if (chk_lat) check({tag, "_latency"}, n, 32'd5);
      e = (q.size() > 0) ? q.pop_front() : '0;
      check({tag, "_s"}, {16'd0, o_s}, {16'd0, e.s});
      check({tag, "_cout"}, {31'd0, o_carry_out}, {31'd0, e.c});
      check({tag, "_ovf"}, {31'd0, o_overflow}, {31'd0, e.v});
      check({tag, "_ready_done"}, {31'd0, o_ready}, 32'd0);
   endtask

   // Complete the result handshake and confirm return to IDLE.
   task automatic release_result(input string tag);
      i_ready = 1'b1;
      tick();
      check({tag, "_idle_valid"}, {31'd0, o_valid}, 32'd0);
      check({tag, "_idle_ready"}, {31'd0, o_ready}, 32'd1);
      check({tag, "_idle_s"}, {16'd0, o_s}, 32'd0);
   endtask

   initial begin
      logic [15:0] held_s;
      logic        held_c, held_v;
      tick();
      tick();
      check("rst_ready", {31'd0, o_ready}, 32'd1);
      check("rst_valid", {31'd0, o_valid}, 32'd0);
      check("rst_s", {16'd0, o_s}, 32'd0);
      check("rst_cout", {31'd0, o_carry_out}, 32'd0);
      check("rst_ovf", {31'd0, o_overflow}, 32'd0);
      rst_n = 1'b1;
      tick();

      accept(16'h1234, 16'h1111, 1'b0);
      get_result("basic", 1'b1);
      release_result("basic");

      accept(16'hFFFF, 16'h0001, 1'b0);
      get_result("carry_chain", 1'b1);
      release_result("carry_chain");

      accept(16'hFFFF, 16'hFFFF, 1'b1);
      get_result("all_ones_cin", 1'b1);
      release_result("all_ones_cin");

      accept(16'h7FFF, 16'h0001, 1'b0);
      get_result("pos_ovf", 1'b1);
      release_result("pos_ovf");

      accept(16'h8000, 16'h8000, 1'b0);
      get_result("neg_ovf", 1'b1);
      release_result("neg_ovf");

      i_ready = 1'b0;
      accept(16'h0123, 16'h4567, 1'b1);
      get_result("bp", 1'b0);
      held_s = o_s;
      held_c = o_carry_out;
      held_v = o_overflow;
      for (int i = 0; i < 3; i++) begin
         i_valid    = 1'b1;
         i_a        = 16'hDEAD;
         i_b        = 16'hBEEF;
         i_carry_in = 1'b1;
         tick();
         check("bp_hold_valid", {31'd0, o_valid}, 32'd1);
         check("bp_hold_ready", {31'd0, o_ready}, 32'd0);
         check("bp_hold_s", {16'd0, o_s}, {16'd0, held_s});
         check("bp_hold_cout", {31'd0, o_carry_out}, {31'd0, held_c});
         check("bp_hold_ovf", {31'd0, o_overflow}, {31'd0, held_v});
      end
      i_valid = 1'b0;
      release_result("bp");

      accept(16'h00F0, 16'h0010, 1'b0);
      i_a = 16'hAAAA;
      i_b = 16'h5555;
      get_result("late_change", 1'b1);
      release_result("late_change");

      accept(16'h4321, 16'h1234, 1'b0);
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst_valid", {31'd0, o_valid}, 32'd0);
      check("midrst_ready", {31'd0, o_ready}, 32'd1);
      check("midrst_s", {16'd0, o_s}, 32'd0);
      void'(q.pop_front());
      for (int i = 0; i < 6; i++) begin
         tick();
         check("midrst_no_valid", {31'd0, o_valid}, 32'd0);
      end

      accept(16'h0005, 16'h000A, 1'b1);
      get_result("post_rst", 1'b1);
      release_result("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Multi-cycle N-bit adder built by sequencing one shared ripple_carry_adder_4 over the operand nibbles, LSB nibble first. Carry is registered between cycles. Trades latency for area; it is the sequencer that owns and schedules the 4-bit adder datapath. Valid/ready handshake on both input and result sides.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration-time assertion)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  reset, synchronous, active-low
i_valid  in  1  operand request valid
o_ready  out  1  block can accept operands (high only in IDLE)
i_a  in  WIDTH  operand A (unsigned / two's complement)
i_b  in  WIDTH  operand B
i_carry_in  in  1  carry into nibble 0
o_valid  out  1  result valid
i_ready  in  1  consumer accepts result
o_s  out  WIDTH  sum, modulo 2^WIDTH
o_carry_out  out  1  carry out of MSB nibble
o_overflow  out  1  signed overflow: a[MSB]==b[MSB] and s[MSB]!=a[MSB]

Behaviour:
- Clock/reset (already decided): single clock i_clk; reset i_rst_n is synchronous and active-low; reset has priority over all other inputs.
- NUM_NIB = WIDTH/4. Internal registers: a_q, b_q, sum_q (WIDTH), carry_q, nibble index idx (clog2(NUM_NIB), min 1 bit), state.
- Reset values: state=IDLE, so o_ready=1 once i_rst_n is sampled low. o_valid=0, o_s=0, o_carry_out=0, o_overflow=0, idx=0, carry_q=0.
- States:
  - IDLE: o_ready=1. If i_valid, capture i_a, i_b and i_carry_in into a_q, b_q, carry_q; set idx=0; go to ADD.
  - ADD: o_ready=0. The adder sees a_q[4*idx+:4], b_q[4*idx+:4] and carry_q. Write the adder sum into sum_q[4*idx+:4], write its carry into carry_q, increment idx. When idx==NUM_NIB-1, go to DONE.
  - DONE: o_valid=1. o_s=sum_q; o_carry_out=carry_q; o_overflow is computed from a_q, b_q and sum_q MSBs. If i_ready, go to IDLE; otherwise hold.
- Latency: acceptance edge at cycle T; o_valid high from cycle T+NUM_NIB+1 (WIDTH=16: o_valid high 5 cycles after the accept cycle).
- Outputs are registered or decoded from registered state only; there is no combinational path from i_valid/i_ready to any output.
- o_s, o_carry_out and o_overflow are stable throughout DONE. They read 0 outside DONE.
- i_valid outside IDLE is ignored (o_ready=0). Changes on i_a/i_b/i_carry_in after acceptance do not affect the result.
- No back-to-back overlap: after the result handshake (DONE with i_ready=1), the next acceptance is earliest in the following IDLE cycle. Throughput is one op per NUM_NIB+2 cycles.
- i_ready while not in DONE has no effect.
- Carry wrap: the final carry goes only to o_carry_out and is never fed back. idx wraps to 0 on each new acceptance.
- WIDTH=4: single ADD cycle, identical function to one ripple_carry_adder_4 call plus registering.
- Reset mid-operation (any state): next cycle is IDLE with all outputs at reset values. The aborted operation never produces o_valid.

Decomposition:
- Package adder_ctrl_pkg:
  - NIBBLE_W=4
  - state enum typedef (IDLE, ADD, DONE; 2-bit logic)
  - function computing signed overflow from three MSBs
- Single sub-module: one instance of the existing ripple_carry_adder_4 (i_a, i_b, i_carry_in, o_s, o_carry_out). All nibble muxing, sequencing and registers live in nibble_serial_adder_ctrl. No other sub-modules.

Test Plan (WIDTH=16, i_ready=1 unless stated):
- 0x1234 + 0x1111, cin=0 -> o_s=0x2345, cout=0, ovf=0. o_valid rises exactly 5 cycles after the accept cycle; o_ready=0 during ADD/DONE.
- 0xFFFF + 0x0001, cin=0 -> o_s=0x0000, cout=1, ovf=0 (carry propagates through all 4 nibbles). 0xFFFF + 0xFFFF, cin=1 -> o_s=0xFFFF, cout=1, ovf=0.
- 0x7FFF + 0x0001, cin=0 -> o_s=0x8000, cout=0, ovf=1. 0x8000 + 0x8000, cin=0 -> o_s=0x0000, cout=1, ovf=1.
- Backpressure: hold i_ready=0 for 3 cycles in DONE while driving i_valid=1 with new operands -> o_s/o_carry_out/o_overflow unchanged, o_ready=0, new operands not accepted. Then i_ready=1 -> IDLE next cycle, o_valid=0, o_ready=1.
- Operand change after accept: accept 0x00F0 + 0x0010, then change i_a to 0xAAAA the next cycle -> result 0x0100, cout=0.
- Reset mid-op: drive i_rst_n=0 for one cycle while idx=2 -> next cycle IDLE, o_valid=0, o_s=0. Then 0x0005 + 0x000A, cin=1 -> o_s=0x0010, cout=0, ovf=0.
